mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU's word bus: answers the CPU's `MAR`/`write`/`MBR_W` requests with read data on `MBR_R` and commits writes. It owns the program/data word array and includes a boot loader. After reset, the loader streams an image into the array through a valid/ready port while asserting `busy`; the testbench holds the CPU in reset until `busy` drops. It sits between the CPU and the testbench, in place of file-initialised memory.

## Interface
Parameters:
- `BITS_DATA`, 32: word width.
- `BITS_ADDR`, 16: CPU address width.
- `DEPTH_LOG2`, 16: array holds 2^`DEPTH_LOG2` words. `DEPTH_LOG2` ≤ `BITS_ADDR`; upper `MAR` bits are ignored, so addresses alias.
- `PROT_LIMIT`, 16'h0100: first writable address when write protection is compiled in.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `MAR`, in, `BITS_ADDR`: CPU word address.
- `MBR_W`, in, `BITS_DATA`: CPU write data.
- `write`, in, 1: CPU write strobe.
- `MBR_R`, out, `BITS_DATA`: read data for `MAR`.
- `load_valid`, in, 1: loader word present.
- `load_data`, in, `BITS_DATA`: loader word.
- `load_last`, in, 1: current loader word is the final one.
- `load_ready`, out, 1: loader accepts a word this cycle.
- `busy`, out, 1: load in progress; CPU must be held in reset.
- `wr_fault`, out, 1: sticky protected-write flag.
- `fault_addr`, out, `BITS_ADDR`: `MAR` of the first faulting write.

## Operation
- States: LOAD and RUN. Reset forces LOAD and sets `load_ptr`=0. Reset does not clear array contents.
- LOAD:
  - `load_ready`=1 and `busy`=1.
  - On each edge with `load_valid`, write `load_data` to `mem[load_ptr]` and increment `load_ptr`.
  - An accepted word with `load_last`=1, or an accepted word at `load_ptr`=2^`DEPTH_LOG2`−1, moves the FSM to RUN. The pointer never wraps.
  - CPU `write` is ignored in LOAD.
- RUN:
  - `load_ready`=0 and `busy`=0; `load_valid` is ignored.
  - On each edge with `write`=1, `mem[MAR[DEPTH_LOG2-1:0]]` ← `MBR_W`.
- Read path: `MBR_R` = `mem[MAR[DEPTH_LOG2-1:0]]`, combinational, in every state. There is no read strobe; the CPU samples it one cycle after driving `MAR`.
- Read during write to the same address: `MBR_R` shows the old word until the edge and the new word after it.
- Reset mid-load: the FSM returns to LOAD with `load_ptr`=0. Words already written remain but are overwritten by the new stream.
- Reset in RUN: the FSM re-enters LOAD. A reload is mandatory before `busy` drops.

## Timing
- Reset values:
  - state = LOAD, `load_ptr`=0.
  - `busy`=1 and `load_ready`=1, both decoded from state.
  - `wr_fault`=0, `fault_addr`=0.
  - `MBR_R` is not reset; it reflects array contents.
- Loader throughput: one word per cycle. Zero-cycle acceptance: the word is accepted on the same edge that `load_valid`·`load_ready` is seen.
- After the edge accepting the last word, `busy` and `load_ready` are 0 in the following cycle. A CPU write in that cycle is honoured.
- CPU read latency: combinational, valid within the cycle `MAR` is stable.
- CPU write latency: committed at the edge where `write` is sampled high.

## Configuration
- Macro: `MEM_RESPONDER_WRITE_PROTECT_EN`.
- Defined:
  - In RUN, a CPU write with `MAR` < `PROT_LIMIT` is dropped and `wr_fault` is set at that edge.
  - `wr_fault` stays set until reset.
  - `fault_addr` captures `MAR` only on the first fault.
  - Loader writes are never protected.
- Undefined: all RUN writes commit, and `wr_fault`/`fault_addr` are tied to 0.

## Test plan
- Reset, then stream 0xA0000001, 0xA0000002, 0xA0000003 (last) → words land at addresses 0..2; `busy` falls the cycle after the third word; `MAR`=2 reads 0xA0000003.
- `load_valid` toggling 1,0,1 with `load_last` on the second accepted word → exactly two words written; addresses stay contiguous; no write on the idle cycle.
- RUN: `write`=1, `MAR`=0x0200, `MBR_W`=0xDEADBEEF → `MBR_R` reads the old value before the edge and 0xDEADBEEF after it.
- Assert reset after 5 of 10 load words, then stream 0x11111111 (last) → `mem[0]`=0x11111111, words 1–4 retain their old values, and `busy` falls.
- With the macro defined: RUN write to 0x0010, then to 0x0020 → both dropped; `wr_fault`=1; `fault_addr`=0x0010. Write to 0x0100 commits. Without the macro, all three writes commit and `wr_fault` stays 0.
- With `DEPTH_LOG2`=4: stream 16 words with no `load_last` → the FSM enters RUN after word 16; a 17th `load_valid` is ignored; `MAR`=0x0013 aliases to address 3.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: word array with combinational read, CPU write port and
// a streaming boot loader. Optional write protection via MEM_RESPONDER_WRITE_PROTECT_EN.
module mem_responder #(
    parameter int                   BITS_DATA  = 32,
    parameter int                   BITS_ADDR  = 16,
    parameter int                   DEPTH_LOG2 = 16,
    parameter logic [BITS_ADDR-1:0] PROT_LIMIT = 16'h0100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITS_ADDR-1:0] MAR,
    input  logic [BITS_DATA-1:0] MBR_W,
    input  logic                 write,
    output logic [BITS_DATA-1:0] MBR_R,
    input  logic                 load_valid,
    input  logic [BITS_DATA-1:0] load_data,
    input  logic                 load_last,
    output logic                 load_ready,
    output logic                 busy,
    output logic                 wr_fault,
    output logic [BITS_ADDR-1:0] fault_addr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] load_ptr_q, load_ptr_d;

    logic [BITS_DATA-1:0]  mem [DEPTH];
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [BITS_DATA-1:0]  mem_wdata;

    logic [DEPTH_LOG2-1:0] mem_idx;
    logic                  ptr_at_end;
    logic                  prot_hit;

    // Upper MAR bits are dropped so addresses alias onto the array.
    assign mem_idx    = MAR[DEPTH_LOG2-1:0];
    assign ptr_at_end = (load_ptr_q == {DEPTH_LOG2{1'b1}});

    assign busy       = (state_q == ST_LOAD);
    assign load_ready = (state_q == ST_LOAD);

    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        mem_we     = 1'b0;
        mem_waddr  = load_ptr_q;
        mem_wdata  = load_data;
        case (state_q)
            ST_LOAD: begin
                if (load_valid) begin
                    mem_we = 1'b1;
                    // Pointer saturates at the top so it can never wrap onto word 0.
                    if (!ptr_at_end) begin
                        load_ptr_d = load_ptr_q + 1'b1;
                    end
                    if (load_last || ptr_at_end) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                if (write && !prot_hit) begin
                    mem_we    = 1'b1;
                    mem_waddr = mem_idx;
                    mem_wdata = MBR_W;
                end
            end
        endcase
        // No array writes on a reset edge; contents otherwise survive reset.
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            load_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign MBR_R = mem[mem_idx];

`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
    logic                 wr_fault_q, wr_fault_d;
    logic [BITS_ADDR-1:0] fault_addr_q, fault_addr_d;

    // Full MAR is compared, so aliased copies of the low region stay writable.
    assign prot_hit = (MAR < PROT_LIMIT);

    always_comb begin
        wr_fault_d   = wr_fault_q;
        fault_addr_d = fault_addr_q;
        if (state_q == ST_RUN && write && prot_hit) begin
            wr_fault_d = 1'b1;
            if (!wr_fault_q) begin
                fault_addr_d = MAR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_fault_q   <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            wr_fault_q   <= wr_fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign wr_fault   = wr_fault_q;
    assign fault_addr = fault_addr_q;
`else
    assign prot_hit   = 1'b0;
    assign wr_fault   = 1'b0;
    assign fault_addr = '0;

    // PROT_LIMIT only matters with protection built in; this keeps it referenced.
    if (PROT_LIMIT == '0) begin : g_prot_region_empty
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: behavioural model checked every cycle plus
// hand-computed expectations; a second small-depth instance covers saturation/aliasing.
module tb_mem_responder;

`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif
    localparam int DEPTH_A = 1 << 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: default parameters
    logic        reset = 1'b1;
    logic [15:0] mar = '0;
    logic [31:0] mbr_w = '0;
    logic        wr = 1'b0;
    logic [31:0] mbr_r;
    logic        lv = 1'b0;
    logic [31:0] ld = '0;
    logic        ll = 1'b0;
    logic        lrdy, busy, wr_fault;
    logic [15:0] fault_addr;

    mem_responder dut_a (
        .clk(clk), .reset(reset), .MAR(mar), .MBR_W(mbr_w), .write(wr),
        .MBR_R(mbr_r), .load_valid(lv), .load_data(ld), .load_last(ll),
        .load_ready(lrdy), .busy(busy), .wr_fault(wr_fault), .fault_addr(fault_addr)
    );

    // Instance B: 16-word array
    logic        reset_b = 1'b1;
    logic [15:0] mar_b = '0;
    logic [31:0] mbr_w_b = '0;
    logic        wr_b = 1'b0;
    logic [31:0] mbr_r_b;
    logic        lv_b = 1'b0;
    logic [31:0] ld_b = '0;
    logic        ll_b = 1'b0;
    logic        lrdy_b, busy_b, wr_fault_b;
    logic [15:0] fault_addr_b;

    mem_responder #(.DEPTH_LOG2(4)) dut_b (
        .clk(clk), .reset(reset_b), .MAR(mar_b), .MBR_W(mbr_w_b), .write(wr_b),
        .MBR_R(mbr_r_b), .load_valid(lv_b), .load_data(ld_b), .load_last(ll_b),
        .load_ready(lrdy_b), .busy(busy_b), .wr_fault(wr_fault_b), .fault_addr(fault_addr_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of instance A
    logic [31:0] m_mem [int];
    bit          m_valid   = 1'b0;
    bit          m_loading = 1'b1;
    int          m_ptr     = 0;
    bit          m_fault   = 1'b0;
    logic [15:0] m_faddr   = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1; m_loading = 1'b1; m_ptr = 0; m_fault = 1'b0; m_faddr = '0;
        end else if (m_valid) begin
            if (m_loading) begin
                if (lv) begin
                    m_mem[m_ptr] = ld;
                    if (ll || m_ptr == DEPTH_A - 1) m_loading = 1'b0;
                    else m_ptr++;
                end
            end else if (wr) begin
                if (PROT_ON && int'(mar) < 'h100) begin
                    if (!m_fault) m_faddr = mar;
                    m_fault = 1'b1;
                end else begin
                    m_mem[int'(mar) % DEPTH_A] = mbr_w;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", {31'b0, busy}, {31'b0, m_loading});
            chk("load_ready", {31'b0, lrdy}, {31'b0, m_loading});
            chk("wr_fault", {31'b0, wr_fault}, {31'b0, m_fault});
            chk("fault_addr", {16'b0, fault_addr}, {16'b0, m_faddr});
            if (m_mem.exists(int'(mar) % DEPTH_A))
                chk("MBR_R", mbr_r, m_mem[int'(mar) % DEPTH_A]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [31:0] exp);
        mar = a;
        #1;
        chk(name, mbr_r, exp);
        $display("read  %s MAR=%h MBR_R=%h", name, a, mbr_r);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_ready", {31'b0, lrdy}, 32'd1);
        chk("rst_fault", {31'b0, wr_fault}, 32'd0);
        chk("rst_faddr", {16'b0, fault_addr}, 32'd0);
        reset = 1'b0;

        // Three-word image
        lv = 1'b1; ld = 32'hA0000001; tick();
        ld = 32'hA0000002; tick();
        chk("busy_before_last", {31'b0, busy}, 32'd1);
        ld = 32'hA0000003; ll = 1'b1; tick();
        lv = 1'b0; ll = 1'b0;
        #1;
        chk("busy_after_last", {31'b0, busy}, 32'd0);
        chk("ready_after_last", {31'b0, lrdy}, 32'd0);
        rd("load3_w2", 16'h0002, 32'hA0000003);
        rd("load3_w0", 16'h0000, 32'hA0000001);
        rd("load3_w1", 16'h0001, 32'hA0000002);

        // Gapped stream: valid 1,0,1 with last on second accepted word
        reset = 1'b1; tick(); reset = 1'b0;
        lv = 1'b1; ld = 32'hB0000001; tick();
        lv = 1'b0; ld = 32'hBAADBAAD; tick();
        lv = 1'b1; ld = 32'hB0000002; ll = 1'b1; tick();
        lv = 1'b0; ll = 1'b0;
        // CPU write in the first RUN cycle must be honoured
        wr = 1'b1; mar = 16'h0300; mbr_w = 32'h55AA55AA; tick();
        wr = 1'b0;
        rd("first_run_write", 16'h0300, 32'h55AA55AA);
        rd("gap_w0", 16'h0000, 32'hB0000001);
        rd("gap_w1", 16'h0001, 32'hB0000002);
        rd("gap_w2_untouched", 16'h0002, 32'hA0000003);

        // Read during write to the same address
        wr = 1'b1; mar = 16'h0200; mbr_w = 32'h12345678; tick();
        mbr_w = 32'hDEADBEEF;
        #1;
        chk("rdw_old", mbr_r, 32'h12345678);
        tick();
        wr = 1'b0;
        rd("rdw_new", 16'h0200, 32'hDEADBEEF);

        // Reset mid-load, then a one-word image
        reset = 1'b1; tick(); reset = 1'b0;
        lv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ld = 32'hC0000000 + i; tick();
        end
        lv = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
        #1;
        chk("midload_busy", {31'b0, busy}, 32'd1);
        lv = 1'b1; ld = 32'h11111111; ll = 1'b1; tick();
        lv = 1'b0; ll = 1'b0;
        #1;
        chk("reload_busy", {31'b0, busy}, 32'd0);
        rd("reload_w0", 16'h0000, 32'h11111111);
        for (int i = 1; i < 5; i++) rd("reload_keep", 16'(i), 32'hC0000000 + i);

        // Protected region writes
        wr = 1'b1;
        mar = 16'h0010; mbr_w = 32'h0F0F0010; tick();
        mar = 16'h0020; mbr_w = 32'h0F0F0020; tick();
        mar = 16'h0100; mbr_w = 32'h0F0F0100; tick();
        wr = 1'b0;
        #1;
        if (PROT_ON) begin
            chk("prot_fault", {31'b0, wr_fault}, 32'd1);
            chk("prot_faddr", {16'b0, fault_addr}, 32'h0010);
        end else begin
            chk("noprot_fault", {31'b0, wr_fault}, 32'd0);
            chk("noprot_faddr", {16'b0, fault_addr}, 32'd0);
            rd("noprot_0010", 16'h0010, 32'h0F0F0010);
            rd("noprot_0020", 16'h0020, 32'h0F0F0020);
        end
        rd("limit_commit", 16'h0100, 32'h0F0F0100);
        reset = 1'b1; tick(); reset = 1'b0;
        #1;
        chk("fault_cleared", {31'b0, wr_fault}, 32'd0);

        // Instance B: 16 words with no last, 17th ignored, aliasing
        reset_b = 1'b0;
        lv_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ld_b = 32'hD0000000 + i; tick();
            if (i == 14) chk("b_busy_w15", {31'b0, busy_b}, 32'd1);
        end
        #1;
        chk("b_busy_after16", {31'b0, busy_b}, 32'd0);
        chk("b_ready_after16", {31'b0, lrdy_b}, 32'd0);
        ld_b = 32'hEEEEEEEE; tick();
        lv_b = 1'b0;
        mar_b = 16'h0013; #1;
        chk("b_alias_13", mbr_r_b, 32'hD0000003);
        mar_b = 16'h0000; #1;
        chk("b_w0_kept", mbr_r_b, 32'hD0000000);
        mar_b = 16'h000F; #1;
        chk("b_w15", mbr_r_b, 32'hD000000F);
        $display("read  b_alias MAR=000f MBR_R=%h", mbr_r_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
